// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency responder for 128-bit line memory requests.
// Accepts one read or write at a time. mem_ready pulses LATENCY cycles after
// the accepting edge. Storage is 2^ADDR_BITS lines; upper mem_addr bits alias.
//
// Ports:
//   clk        - single clock, rising edge
//   proc_reset - synchronous active-high reset (clears storage too)
//   mem_read   - line read request, held until mem_ready
//   mem_write  - line write request, held until mem_ready
//   mem_addr   - line address (low ADDR_BITS used)
//   mem_wdata  - write line data
//   mem_rdata  - registered read data, 0 except in a read's ready cycle
//   mem_ready  - registered one-cycle completion pulse
//   proto_err  - sticky flag: read+write together in IDLE, or op dropped in WAIT
module line_mem_responder #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         proto_err
);

  localparam int unsigned LINES    = 1 << ADDR_BITS;
  localparam logic [7:0]  CNT_LOAD = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;

  logic                 op_write_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [127:0]         wdata_q;
  logic [127:0]         lines [LINES];

  logic                 accept, illegal, abort;
  logic                 eff_write;
  logic [ADDR_BITS-1:0] eff_addr;
  logic [127:0]         eff_wdata;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[27:ADDR_BITS];

  // With LATENCY=1 the RESP entry coincides with the accepting edge, so the
  // live inputs stand in for the not-yet-latched request.
  always_comb begin
    eff_write = op_write_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    if (state == IDLE) begin
      eff_write = mem_write;
      eff_addr  = mem_addr[ADDR_BITS-1:0];
      eff_wdata = mem_wdata;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    illegal  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read ^ mem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end else if (mem_read && mem_write) begin
          illegal = 1'b1;
        end
      end
      WAIT: begin
        if (op_write_q ? !mem_write : !mem_read) begin
          abort    = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == '0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      proto_err  <= 1'b0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        lines[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mem_ready <= (state_nx == RESP);
      mem_rdata <= '0;
      if (accept) begin
        op_write_q <= mem_write;
        addr_q     <= mem_addr[ADDR_BITS-1:0];
        wdata_q    <= mem_wdata;
      end
      if (illegal || abort) begin
        proto_err <= 1'b1;
      end
      if (state_nx == RESP) begin
        if (eff_write) begin
          lines[eff_addr] <= eff_wdata;
        end else begin
          mem_rdata <= lines[eff_addr];
        end
      end
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one instance at LATENCY=4 and one at
// LATENCY=1 sharing clock and reset.
module tb_line_mem_responder;

  logic         clk;
  logic         proc_reset;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready, proto_err;

  logic         b_read, b_write;
  logic [27:0]  b_addr;
  logic [127:0] b_wdata;
  logic [127:0] b_rdata;
  logic         b_ready, b_err;

  int checks = 0;
  int errors = 0;

  line_mem_responder #(.LATENCY(4), .ADDR_BITS(6)) u_dut (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .proto_err(proto_err)
  );

  line_mem_responder #(.LATENCY(1), .ADDR_BITS(6)) u_dut_l1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(b_read), .mem_write(b_write),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .mem_ready(b_ready), .proto_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
  endtask

  // Issue a request on the LATENCY=4 instance; scrambles addr/data after the
  // accepting edge to confirm the latched values are used.
  task automatic req(input bit wr, input logic [27:0] a, input logic [127:0] d,
                     input string tag, output logic [127:0] rd);
    int n;
    mem_write = wr;
    mem_read  = !wr;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_addr  = ~a;
    mem_wdata = ~d;
    n = 1;
    while (!mem_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd4);
    rd = mem_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    check({tag, "_ready_one_cycle"}, 128'(mem_ready), 128'd0);
    check({tag, "_rdata_zero_after"}, mem_rdata, 128'd0);
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (mem_ready) cnt++;
    end
  endtask

  logic [127:0] rd;
  logic [127:0] dval;
  int           pulses;
  int           gap;

  initial begin
    proc_reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;

    do_reset();
    check("reset_ready", 128'(mem_ready), 128'd0);
    check("reset_rdata", mem_rdata, 128'd0);
    check("reset_err", 128'(proto_err), 128'd0);

    // Write then read same line
    req(1'b1, 28'h3, {16{8'hA5}}, "wr3", rd);
    check("wr3_rdata_in_resp", rd, 128'd0);
    req(1'b0, 28'h3, '0, "rd3", rd);
    check("rd3_data", rd, {16{8'hA5}});

    // Aliasing above ADDR_BITS
    dval = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    req(1'b1, 28'h41, dval, "wr41", rd);
    req(1'b0, 28'h01, '0, "rd01", rd);
    check("alias_data", rd, dval);
    req(1'b0, 28'h10, '0, "rd10", rd);
    check("unwritten_zero", rd, 128'd0);
    check("err_clean", 128'(proto_err), 128'd0);

    // Illegal simultaneous read+write for 3 cycles
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 28'h3;
    tick();
    check("illegal_err_next", 128'(proto_err), 128'd1);
    pulses = int'(mem_ready);
    tick();
    if (mem_ready) pulses++;
    tick();
    if (mem_ready) pulses++;
    mem_read = 1'b0; mem_write = 1'b0;
    check("illegal_no_ready", 128'(pulses), 128'd0);
    req(1'b0, 28'h3, '0, "rd_after_illegal", rd);
    check("rd_after_illegal_data", rd, {16{8'hA5}});
    check("illegal_err_sticky", 128'(proto_err), 128'd1);

    // Read abort: accepted at T0, dropped at T2
    do_reset();
    check("reset2_err", 128'(proto_err), 128'd0);
    mem_read = 1'b1; mem_addr = 28'h5;
    tick();
    tick();
    mem_read = 1'b0;
    tick();
    check("abort_err", 128'(proto_err), 128'd1);
    count_ready(6, pulses);
    check("abort_rd_no_ready", 128'(pulses), 128'd0);
    // Write abort: dropped in WAIT, line must stay 0
    mem_write = 1'b1; mem_addr = 28'h5; mem_wdata = {4{32'hDEAD_BEEF}};
    tick();
    mem_write = 1'b0;
    count_ready(6, pulses);
    check("abort_wr_no_ready", 128'(pulses), 128'd0);
    req(1'b0, 28'h5, '0, "rd5", rd);
    check("abort_wr_line_zero", rd, 128'd0);

    // Reset mid-write
    do_reset();
    req(1'b1, 28'h3, {16{8'h5A}}, "wr3b", rd);
    mem_write = 1'b1; mem_addr = 28'h7; mem_wdata = {4{32'hCAFE_F00D}};
    tick();
    tick();
    proc_reset = 1'b1;
    mem_write = 1'b0;
    tick();
    proc_reset = 1'b0;
    check("rst_mid_ready", 128'(mem_ready), 128'd0);
    check("rst_mid_rdata", mem_rdata, 128'd0);
    check("rst_mid_err", 128'(proto_err), 128'd0);
    count_ready(6, pulses);
    check("rst_mid_no_ready", 128'(pulses), 128'd0);
    req(1'b0, 28'h7, '0, "rd7", rd);
    check("rst_mid_line_zero", rd, 128'd0);
    req(1'b0, 28'h3, '0, "rd3b", rd);
    check("rst_clears_storage", rd, 128'd0);

    // LATENCY=1 instance: fill four lines, then stream reads
    for (int i = 0; i < 4; i++) begin
      b_write = 1'b1; b_addr = 28'(i); b_wdata = {4{32'hC0DE_0000 + 32'(i)}};
      tick();
      check("l1_wr_ready", 128'(b_ready), 128'd1);
      b_write = 1'b0;
      tick();
    end
    b_read = 1'b1;
    b_addr = 28'h0;
    for (int i = 0; i < 4; i++) begin
      gap = 0;
      do begin
        tick();
        gap++;
      end while (!b_ready && gap < 10);
      check("l1_gap", 128'(gap), (i == 0) ? 128'd1 : 128'd2);
      check("l1_data", b_rdata, {4{32'hC0DE_0000 + 32'(i)}});
      b_addr = 28'(i + 1);
    end
    b_read = 1'b0;
    tick();
    check("l1_rdata_idle", b_rdata, 128'd0);
    check("l1_err", 128'(b_err), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request sample to mem_ready (legal range 1..255).
REQ-002 SHALL have parameter ADDR_BITS, default 6, meaning the number of low mem_addr bits that index storage (2^ADDR_BITS lines of 128 bits).
REQ-003 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have proc_reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have mem_read, input, 1: line read request, held until mem_ready.
REQ-006 SHALL have mem_write, input, 1: line write request, held until mem_ready.
REQ-007 SHALL have mem_addr, input, 28: line address.
REQ-008 SHALL have mem_wdata, input, 128: write line data.
REQ-009 SHALL have mem_rdata, output, 128: read line data, registered.
REQ-010 SHALL have mem_ready, output, 1: one-cycle completion pulse, registered.
REQ-011 SHALL have proto_err, output, 1: sticky protocol-violation flag.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-013 In IDLE, a request SHALL be accepted only when exactly one of mem_read or mem_write is high; the block SHALL then latch op, mem_addr[ADDR_BITS-1:0] and mem_wdata.
REQ-014 In IDLE, mem_read and mem_write both high SHALL be ignored, SHALL keep the FSM in IDLE, and SHALL set proto_err.
REQ-015 An accept at edge ending cycle T SHALL go to RESP if LATENCY=1, else to WAIT with counter loaded to LATENCY-2.
REQ-016 In WAIT, the counter SHALL decrement each cycle; at counter 0 the FSM SHALL go to RESP, so that mem_ready is high in cycle T+LATENCY.
REQ-017 A latched write SHALL commit to storage on the edge entering RESP, never earlier.
REQ-018 A latched read SHALL load mem_rdata from storage on the edge entering RESP.
REQ-019 In RESP, mem_ready SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-020 A request present during RESP SHALL NOT be accepted; it SHALL be sampled earliest in the following IDLE cycle, giving a minimum of LATENCY+1 cycles between consecutive mem_ready pulses.
REQ-021 In WAIT, if the latched op signal deasserts, the FSM SHALL abort to IDLE with no storage commit and no mem_ready, and SHALL set proto_err.
REQ-022 Changes to mem_addr or mem_wdata after accept SHALL be ignored; the latched values SHALL be used.
REQ-023 mem_addr bits above ADDR_BITS SHALL be ignored (aliasing modulo 2^ADDR_BITS).
REQ-024 mem_rdata SHALL be 0 in every cycle in which mem_ready is 0, and in a write's RESP cycle.
REQ-025 A read following a write to the same line SHALL return the written data.
REQ-026 proto_err SHALL stay at 1 until reset.

Reset
REQ-027 proc_reset high at an edge SHALL force IDLE, mem_ready=0, mem_rdata=0, proto_err=0, counter=0 and all storage lines to 0.
REQ-028 Reset during WAIT or RESP SHALL discard the pending request; a pending write SHALL NOT commit, and no mem_ready SHALL follow.
REQ-029 Requests SHALL be ignored in any cycle where proc_reset is high.

Verification
REQ-030 Write then read, LATENCY=4: write addr 0x3 data 128'hA5..A5 at T0 -> mem_ready at T4; read addr 0x3 at T5 -> mem_ready at T9 with mem_rdata=128'hA5..A5.
REQ-031 Aliasing, ADDR_BITS=6: write 0x41 data D, read 0x01 -> returns D; read of an unwritten line after reset -> returns 0.
REQ-032 Abort: read accepted at T0, mem_read dropped at T2 -> no mem_ready, proto_err=1; then write to the same line with mem_write dropped in WAIT -> line still 0.
REQ-033 Illegal request: mem_read=mem_write=1 for 3 cycles -> FSM stays IDLE, no mem_ready, proto_err=1 from the next cycle on.
REQ-034 Reset mid-write: write accepted, proc_reset pulsed in WAIT -> no mem_ready, all outputs 0, later read of that line -> 0.
REQ-035 Cache-style back-to-back, LATENCY=1: mem_read held continuously with the address changing right after each mem_ready -> pulses every 2 cycles, each with the correct line data.
